// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single-precision layout, exponent
// constants and the per-stage payloads of the pipelined multiplier.
// FMUL_PIPE_ROUND_EN adds the guard/sticky bits to the stage-2 payload.
package fpu_pkg;

   typedef struct packed {
      logic        s;
      logic [7:0]  e;
      logic [22:0] m;
   } fp32_t;

   localparam int         EXP_BIAS = 127;
   localparam logic [7:0] EXP_MAX  = 8'hFF;

   // Exponents are widened to 10 bits and treated as signed so that both
   // underflow (<= 0) and overflow (>= 255) remain visible after the sum.
   typedef logic [9:0] exp_ext_t;

   // 24-bit significand times a 12-bit slice of the other significand
   localparam int PP_W = 36;

   // Stage 1 -> stage 2: unpacked sign/zero, exponent sum, partial products
   typedef struct packed {
      logic            sign;
      logic            zero;
      exp_ext_t        e_sum;
      logic [PP_W-1:0] pp_lo;
      logic [PP_W-1:0] pp_hi;
   } s1_t;

   // Stage 2 -> stage 3: normalized fraction and adjusted exponent
   typedef struct packed {
      logic        sign;
      logic        zero;
      exp_ext_t    e_tmp;
      logic [22:0] frac;
`ifdef FMUL_PIPE_ROUND_EN
      logic        guard;
      logic        sticky;
`endif
   } s2_t;

   // Significand with the implicit leading one restored
   function automatic logic [23:0] sig_of(input fp32_t f);
      return {1'b1, f.m};
   endfunction

   // No denormals: any operand with a zero exponent is zero
   function automatic logic is_zero(input fp32_t f);
      return f.e == 8'h00;
   endfunction

endpackage

// File: rtl/fmul_pipe_if.sv
// Request/response channel of the pipelined FP multiplier. The producer
// side drives operands and tag plus out_ready; the multiplier drives
// in_ready and the result channel.
interface fmul_pipe_if #(
   parameter int TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      x;
   logic [31:0]      y;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      res;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, x, y, in_tag, out_ready,
      input  in_ready, out_valid, res, out_tag
   );

   modport slave (
      input  in_valid, x, y, in_tag, out_ready,
      output in_ready, out_valid, res, out_tag
   );
endinterface

// File: rtl/fmul_pipe_ctrl.sv
// Pipeline control for the 3-stage multiplier: holds the stage valid bits
// and produces the bubble-collapsing advance enables. Stage K moves when it
// is empty or when the stage after it moves, so bubbles are squeezed out.
module fmul_pipe_ctrl (
   input  logic clk,
   input  logic rstn,
   input  logic in_valid,
   input  logic out_ready,
   output logic in_ready,
   output logic adv1,
   output logic adv2,
   output logic adv3,
   output logic out_valid
);

   logic v1, v2, v3;

   // Advance chain evaluated back to front; in_ready is held low in reset
   always_comb begin
      adv3     = !v3 || out_ready;
      adv2     = !v2 || adv3;
      adv1     = !v1 || adv2;
      in_ready = rstn && adv1;
   end

   // Stage valid bits; a stage that advances takes its predecessor's valid
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else begin
         // NOTE: non-blocking so every stage samples the pre-edge value of
         // the stage before it; blocking would let an op skip stages.
         if (adv1) v1 <= in_valid;
         if (adv2) v2 <= v1;
         if (adv3) v3 <= v2;
      end
   end

   assign out_valid = v3;

endmodule

// File: rtl/fmul_pipe.sv
// Pipelined IEEE-754 single-precision multiplier, 3 stages, valid/ready on
// both sides, with an opaque tag carried alongside each op.
//   S1: unpack, sign, exponent sum, two 24x12 partial products
//   S2: sum partial products, normalize
//   S3: optional round, range check (flush-to-zero / +-inf), pack
// Simplified semantics: no denormals or NaN; e==255 is an ordinary number.
// Build option: define FMUL_PIPE_ROUND_EN for round-to-nearest-even;
// without it the fraction is truncated and no rounding adder exists.
module fmul_pipe
   import fpu_pkg::*;
#(
   parameter int TAG_W = 5
) (
   input logic        clk,
   input logic        rstn,
   fmul_pipe_if.slave bus
);

   logic adv1, adv2, adv3;
   logic in_ready, out_valid;

   fmul_pipe_ctrl u_ctrl (
      .clk      (clk),
      .rstn     (rstn),
      .in_valid (bus.in_valid),
      .out_ready(bus.out_ready),
      .in_ready (in_ready),
      .adv1     (adv1),
      .adv2     (adv2),
      .adv3     (adv3),
      .out_valid(out_valid)
   );

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;

   // ---------------------------------------------------------------- S1
   fp32_t            fx, fy;
   logic [23:0]      sig_x, sig_y;
   s1_t              s1_d, s1_q;
   logic [TAG_W-1:0] tag1_q;

   assign fx    = bus.x;
   assign fy    = bus.y;
   assign sig_x = sig_of(fx);
   assign sig_y = sig_of(fy);

   // Unpack operands and form the two partial products
   always_comb begin
      s1_d.sign  = fx.s ^ fy.s;
      s1_d.zero  = is_zero(fx) || is_zero(fy);
      s1_d.e_sum = {2'b00, fx.e} + {2'b00, fy.e} - exp_ext_t'(EXP_BIAS);
      s1_d.pp_lo = {12'b0, sig_x} * {24'b0, sig_y[11:0]};
      s1_d.pp_hi = {12'b0, sig_x} * {24'b0, sig_y[23:12]};
   end

   // Stage-1 datapath register, loaded whenever stage 1 advances
   always_ff @(posedge clk) begin
      // NOTE: datapath registers carry no reset; the valid bits alone decide
      // whether their contents mean anything, so reset only touches control.
      if (adv1) begin
         s1_q   <= s1_d;
         tag1_q <= bus.in_tag;
      end
   end

   // ---------------------------------------------------------------- S2
   s2_t              s2_d, s2_q;
   logic [TAG_W-1:0] tag2_q;
`ifdef FMUL_PIPE_ROUND_EN
   logic [47:0]      prod;
`else
   logic [24:0]      prod_top;   // product bits [47:23]; lower bits not kept
`endif

   // Sum partial products and normalize to a 1.f significand
   always_comb begin
      // NOTE: every field gets a default first so no path through this block
      // leaves a variable unassigned, which would infer a latch.
      s2_d      = '0;
      s2_d.sign = s1_q.sign;
      s2_d.zero = s1_q.zero;
`ifdef FMUL_PIPE_ROUND_EN
      prod = {12'b0, s1_q.pp_lo} + {s1_q.pp_hi, 12'b0};
      if (prod[47]) begin
         s2_d.frac   = prod[46:24];
         s2_d.guard  = prod[23];
         s2_d.sticky = |prod[22:0];
         s2_d.e_tmp  = s1_q.e_sum + 10'd1;
      end else begin
         s2_d.frac   = prod[45:23];
         s2_d.guard  = prod[22];
         s2_d.sticky = |prod[21:0];
         s2_d.e_tmp  = s1_q.e_sum;
      end
`else
      prod_top = 25'(({12'b0, s1_q.pp_lo} + {s1_q.pp_hi, 12'b0}) >> 23);
      if (prod_top[24]) begin
         s2_d.frac  = prod_top[23:1];
         s2_d.e_tmp = s1_q.e_sum + 10'd1;
      end else begin
         s2_d.frac  = prod_top[22:0];
         s2_d.e_tmp = s1_q.e_sum;
      end
`endif
   end

   // Stage-2 datapath register
   always_ff @(posedge clk) begin
      if (adv2) begin
         s2_q   <= s2_d;
         tag2_q <= tag1_q;
      end
   end

   // ---------------------------------------------------------------- S3
   logic [22:0]      frac3;
   exp_ext_t         e3;
   logic [31:0]      res_d;
   logic [31:0]      res_q;
   logic [TAG_W-1:0] tag3_q;
`ifdef FMUL_PIPE_ROUND_EN
   logic             carry;
`endif

   // Round (optional), then clamp the exponent range and pack the result
   always_comb begin
      frac3 = s2_q.frac;
      e3    = s2_q.e_tmp;
`ifdef FMUL_PIPE_ROUND_EN
      carry = 1'b0;
      if (s2_q.guard && (s2_q.sticky || s2_q.frac[0])) begin
         // A carry out leaves frac3 at zero: 1.111..1 + ulp = 10.000..0
         {carry, frac3} = {1'b0, s2_q.frac} + 24'd1;
         if (carry) e3 = s2_q.e_tmp + 10'd1;
      end
`endif
      if (s2_q.zero || $signed(e3) <= $signed(10'sd0))
         res_d = 32'h0000_0000;
      else if ($signed(e3) >= $signed(10'sd255))
         res_d = {s2_q.sign, EXP_MAX, 23'b0};
      else
         res_d = {s2_q.sign, e3[7:0], frac3};
   end

   // Output register; holds steady while the consumer stalls
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         res_q  <= 32'h0000_0000;
         tag3_q <= '0;
      end else if (adv3) begin
         res_q  <= res_d;
         tag3_q <= tag2_q;
      end
   end

   assign bus.res     = res_q;
   assign bus.out_tag = tag3_q;

endmodule

// File: tb/tb_fmul_pipe.sv
// Self-checking bench for fmul_pipe: directed cases with literal results,
// backpressure and mid-flight reset scenarios, then randomized traffic.
// A scoreboard of model results checks every output handshake in order.
module tb_fmul_pipe;

   localparam int TAG_W = 5;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   fmul_pipe_if #(.TAG_W(TAG_W)) bus ();

   fmul_pipe #(.TAG_W(TAG_W)) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   int          n_total = 0;
   int          n_pass  = 0;
   int unsigned cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: exact 48-bit significand product, normalize, optional RNE,
   // then flush/saturate on the final exponent.
   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
      longint unsigned p;
      int              e;
      logic            s;
      logic [22:0]     frac;
      logic            g, st;
      if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return 32'h0;
      s = a[31] ^ b[31];
      p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47]) begin
         frac = p[46:24]; g = p[23]; st = |p[22:0]; e++;
      end else begin
         frac = p[45:23]; g = p[22]; st = |p[21:0];
      end
`ifdef FMUL_PIPE_ROUND_EN
      if (g && (st || frac[0])) begin
         if (frac == 23'h7FFFFF) begin frac = 23'h0; e++; end
         else frac = frac + 23'd1;
      end
`else
      if (g && st) frac = frac;   // truncation: guard/sticky ignored
`endif
      if (e <= 0) return 32'h0;
      if (e >= 255) return {s, 8'hFF, 23'h0};
      return {s, e[7:0], frac};
   endfunction

   function automatic logic [31:0] rand_fp();
      logic [7:0]  e;
      logic [22:0] m;
      if ($urandom_range(0, 3) == 0) e = 8'($urandom_range(0, 255));
      else                           e = 8'($urandom_range(60, 194));
      m = 23'($urandom);
      if ($urandom_range(0, 2) == 0) m = m & 23'h7FF000;   // makes ties reachable
      return {1'($urandom), e, m};
   endfunction

   // ------------------------------------------------------ scoreboard
   typedef struct {
      logic [31:0]      res;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t             sb[$];
   exp_t             head;
   logic             prev_stall = 1'b0;
   logic [31:0]      prev_res;
   logic [TAG_W-1:0] prev_tag;

   always @(negedge clk) begin
      if (!rstn) begin
         sb.delete();
         prev_stall = 1'b0;
         check("rst_out_valid", bus.out_valid, 1'b0);
         check("rst_in_ready", bus.in_ready, 1'b0);
      end else begin
         check("in_ready", bus.in_ready, (sb.size() < 3) || bus.out_ready);
         if (prev_stall) begin
            check("hold_valid", bus.out_valid, 1'b1);
            check("hold_res", bus.res, prev_res);
            check("hold_tag", bus.out_tag, prev_tag);
         end
         if (bus.out_valid) check("out_valid_has_op", sb.size() > 0, 1'b1);
         if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
            head = sb.pop_front();
            check("sb_res", bus.res, head.res);
            check("sb_tag", bus.out_tag, head.tag);
         end
         if (bus.in_valid && bus.in_ready)
            sb.push_back('{model(bus.x, bus.y), bus.in_tag});
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_res   = bus.res;
         prev_tag   = bus.out_tag;
      end
   end

   // One op with out_ready high: literal result, tag and 3-cycle latency
   task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] t, input logic [31:0] expv);
      int unsigned acc_cyc, take_cyc;
      bit          got;
      check({name, "_model"}, model(a, b), expv);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      bus.x = a; bus.y = b; bus.in_tag = t; bus.in_valid = 1'b1;
      got = 1'b0; acc_cyc = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin got = 1'b1; acc_cyc = cyc + 1; end
      end
      check({name, "_accept"}, got, 1'b1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      got = 1'b0; take_cyc = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            got = 1'b1; take_cyc = cyc + 1;
            check({name, "_res"}, bus.res, expv);
            check({name, "_tag"}, bus.out_tag, t);
         end
      end
      check({name, "_out_seen"}, got, 1'b1);
      check({name, "_latency"}, take_cyc - acc_cyc, 3);
   endtask

   logic             acc;
   int               n_acc, n_out;
   int unsigned      last_take;
   logic [31:0]      snap_res;
   logic [TAG_W-1:0] snap_tag, rtag;

   initial begin
      bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
      #12;
      check("reset_out_valid", bus.out_valid, 1'b0);
      check("reset_in_ready", bus.in_ready, 1'b0);
      check("reset_res", bus.res, 32'h0);
      check("reset_tag", bus.out_tag, 5'd0);
      #11 rstn = 1'b1;

      // T1..T4 plus one normalization-shift case
      directed("t1_stream",   32'h3FC00000, 32'h40000000, 5'd3, 32'h40400000);
      directed("t2_neg",      32'hC0000000, 32'h40400000, 5'd1, 32'hC0C00000);
      directed("t2_zero",     32'h00000000, 32'hC0400000, 5'd2, 32'h00000000);
      directed("t2_norm",     32'h3FC00000, 32'h3FC00000, 5'd5, 32'h40100000);
      directed("t3_ovf",      32'h7F000000, 32'h7F000000, 5'd6, 32'h7F800000);
      directed("t3_unf",      32'h00800000, 32'h00800000, 5'd7, 32'h00000000);
      directed("t3_unf_sign", 32'h80800000, 32'h00800000, 5'd8, 32'h00000000);
`ifdef FMUL_PIPE_ROUND_EN
      directed("t4_round",    32'h3F800001, 32'h3FC00000, 5'd9, 32'h3FC00002);
`else
      directed("t4_round",    32'h3F800001, 32'h3FC00000, 5'd9, 32'h3FC00001);
`endif

      // T5: backpressure with 5 back-to-back ops
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      n_acc = 0; n_out = 0; last_take = 0;
      bus.x = rand_fp(); bus.y = rand_fp(); bus.in_tag = 5'd0; bus.in_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.out_valid && bus.out_ready) begin
            check("t5_order", bus.out_tag, n_out);
            if (n_out > 0) check("t5_gap", cyc + 1 - last_take, 1);
            last_take = cyc + 1;
            n_out++;
         end
         if (i == 3) begin
            snap_res = bus.res; snap_tag = bus.out_tag;
            check("t5_valid_full", bus.out_valid, 1'b1);
         end
         if (i == 6) begin
            check("t5_accepted", n_acc, 3);
            check("t5_in_ready_low", bus.in_ready, 1'b0);
            check("t5_res_stable", bus.res, snap_res);
            check("t5_tag_stable", bus.out_tag, snap_tag);
            check("t5_head_tag", bus.out_tag, 5'd0);
         end
         acc = bus.in_valid && bus.in_ready;
         @(posedge clk); #1;
         if (acc) begin
            n_acc++;
            if (n_acc < 5) begin
               bus.x = rand_fp(); bus.y = rand_fp(); bus.in_tag = TAG_W'(n_acc);
            end else bus.in_valid = 1'b0;
         end
         if (i == 6) bus.out_ready = 1'b1;
      end
      check("t5_count", n_out, 5);

      // T6: asynchronous reset with two ops in flight
      bus.out_ready = 1'b0;
      n_acc = 0;
      bus.x = rand_fp(); bus.y = rand_fp(); bus.in_tag = 5'd20; bus.in_valid = 1'b1;
      for (int i = 0; i < 10 && n_acc < 2; i++) begin
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
         @(posedge clk); #1;
         if (acc) begin
            n_acc++;
            if (n_acc < 2) begin
               bus.x = rand_fp(); bus.y = rand_fp(); bus.in_tag = 5'd21;
            end else bus.in_valid = 1'b0;
         end
      end
      check("t6_two_accepted", n_acc, 2);
      @(posedge clk); #3;
      check("t6_pre_valid", bus.out_valid, 1'b1);
      rstn = 1'b0;
      #1;
      check("t6_out_valid_now", bus.out_valid, 1'b0);
      check("t6_in_ready_now", bus.in_ready, 1'b0);
      check("t6_res_now", bus.res, 32'h0);
      check("t6_tag_now", bus.out_tag, 5'd0);
      #17 rstn = 1'b1;
      directed("t6_after", 32'h40400000, 32'h40400000, 5'd12, 32'h41100000);

      // Randomized traffic with random backpressure
      rtag = '0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
         @(posedge clk); #1;
         if (acc || !bus.in_valid) begin
            bus.in_valid = ($urandom_range(0, 9) < 7);
            bus.x = rand_fp(); bus.y = rand_fp(); bus.in_tag = rtag;
            rtag = rtag + 1'b1;
         end
         bus.out_ready = ($urandom_range(0, 9) < 7);
      end
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (!acc) bus.in_valid = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("drain_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, checks %0d/%0d", n_pass, n_total);
      $fatal(1);
   end

endmodule
